// File: rtl/mips_dmem_wbuf.sv
// Write buffer between the MIPS memory stage and backing data memory: circular FIFO
// of word writes, drained one entry per acked cycle, with newest-match load forwarding.
module mips_dmem_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_rd_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        wb_full,
  output logic        wb_overflow,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_req,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_ack
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          wr_cmd, push, pop;
  logic [PW-1:0] fwd_idx;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^data_addr[1:0];

  assign wr_cmd      = ~data_rd_wr;
  assign wb_full     = (count_q == CW'(DEPTH));
  assign mem_wr_req  = (count_q != '0);
  assign push        = wr_cmd & ~wb_full;
  assign pop         = mem_wr_req & mem_wr_ack;
  assign wb_overflow = overflow_q;
  assign mem_rd_addr = {data_addr[31:2], 2'b00};
  assign mem_wr_addr = {addr_q[head_q], 2'b00};
  assign mem_wr_data = data_q[head_q];

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_cmd & wb_full);
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage is never cleared; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= data_addr[31:2];
      data_q[tail_q] <= data_out;
    end
  end

  // Walk live entries oldest to newest so the youngest match wins.
  always_comb begin
    data_in = mem_rd_data;
    fwd_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == data_addr[31:2]))
        data_in = data_q[fwd_idx];
    end
  end

endmodule

// File: tb/tb_mips_dmem_wbuf.sv
// Directed plus random bench for mips_dmem_wbuf against a queue-based reference model.
module tb_mips_dmem_wbuf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_rd_wr;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        wb_full;
  logic        wb_overflow;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ack;
  logic        rd_zero;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  logic m_ovf;
  int   errors = 0;
  int   checks = 0;

  mips_dmem_wbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_rd_wr(data_rd_wr), .data_addr(data_addr),
    .data_out(data_out), .data_in(data_in), .wb_full(wb_full),
    .wb_overflow(wb_overflow), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] backing(input logic [31:0] wa);
    return rd_zero ? 32'h0 : ((wa ^ 32'hC0DE_0000) + 32'd7);
  endfunction

  assign mem_rd_data = backing(mem_rd_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a[31:2]) return q[i].d;
    return backing(wa);
  endfunction

  task automatic check_outputs(input string tag, input logic [31:0] a);
    check({tag, ".req"},  {31'h0, mem_wr_req},  {31'h0, q.size() != 0});
    check({tag, ".full"}, {31'h0, wb_full},     {31'h0, q.size() == DEPTH});
    check({tag, ".ovf"},  {31'h0, wb_overflow}, {31'h0, m_ovf});
    check({tag, ".rdaddr"}, mem_rd_addr, {a[31:2], 2'b00});
    check({tag, ".load"}, data_in, model_load(a));
    if (q.size() != 0) begin
      check({tag, ".waddr"}, mem_wr_addr, {q[0].a, 2'b00});
      check({tag, ".wdata"}, mem_wr_data, q[0].d);
    end
  endtask

  task automatic step(input string tag, input logic rw, input logic [31:0] a,
                      input logic [31:0] d, input logic ack);
    logic do_push, do_pop;
    data_rd_wr = rw;
    data_addr  = a;
    data_out   = d;
    mem_wr_ack = ack;
    #1;
    check_outputs(tag, a);
    do_push = !rw && (q.size() < DEPTH);
    do_pop  = ack && (q.size() != 0);
    @(posedge clk);
    if (!reset) begin
      if (!rw && q.size() == DEPTH) m_ovf = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{a: a[31:2], d: d});
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    rd_zero    = 1'b0;
    data_rd_wr = 1'b1;
    data_addr  = 32'h0;
    data_out   = 32'h0;
    mem_wr_ack = 1'b0;
    m_ovf      = 1'b0;
    @(negedge clk);
    // Writes during reset must be ignored.
    step("rst_wr0", 1'b0, 32'h100, 32'hDEAD_0001, 1'b0);
    step("rst_wr1", 1'b0, 32'h104, 32'hDEAD_0002, 1'b1);
    reset = 1'b0;
    step("rst_state", 1'b1, 32'h100, 32'h0, 1'b0);

    // Single write, forwarding against zero backing data, then drain.
    step("w100", 1'b0, 32'h100, 32'h1234_5678, 1'b0);
    rd_zero = 1'b1;
    step("r100", 1'b1, 32'h100, 32'h0, 1'b0);
    step("r100_ack", 1'b1, 32'h100, 32'h0, 1'b1);
    step("r100_empty", 1'b1, 32'h100, 32'h0, 1'b0);
    rd_zero = 1'b0;

    // Duplicate address: newest forwards, both drain in order.
    step("wA", 1'b0, 32'h200, 32'hA, 1'b0);
    step("wB", 1'b0, 32'h200, 32'hB, 1'b0);
    step("r203", 1'b1, 32'h203, 32'h0, 1'b0);
    check("r203.value", data_in, 32'hB);
    step("ackA", 1'b1, 32'h200, 32'h0, 1'b1);
    step("ackB", 1'b1, 32'h200, 32'h0, 1'b1);

    // Fill past capacity; overflow stays sticky through drain.
    for (int i = 0; i < 5; i++)
      step("fill", 1'b0, 32'h400 + 32'(i * 4), 32'h5000 + 32'(i), 1'b0);
    step("full_chk", 1'b1, 32'h410, 32'h0, 1'b0);
    check("full_after4", {31'h0, wb_full}, 32'h1);
    check("ovf_sticky", {31'h0, wb_overflow}, 32'h1);
    for (int i = 0; i < 4; i++)
      step("drain4", 1'b1, 32'h40C, 32'h0, 1'b1);
    step("drained", 1'b1, 32'h400, 32'h0, 1'b0);
    check("not_full", {31'h0, wb_full}, 32'h0);

    // Full plus write plus ack: write dropped, three entries remain.
    pulse_reset();
    for (int i = 0; i < 4; i++)
      step("fill2", 1'b0, 32'h600 + 32'(i * 4), 32'h6000 + 32'(i), 1'b0);
    step("full_wr_ack", 1'b0, 32'h700, 32'h7777, 1'b1);
    step("after_drop", 1'b1, 32'h700, 32'h0, 1'b0);
    check("drop_ovf", {31'h0, wb_overflow}, 32'h1);

    // Two entries held steady while pushing and acking for ten cycles.
    step("to2", 1'b1, 32'h600, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++)
      step("steady", 1'b0, 32'h800 + 32'(i * 4), 32'h8000 + 32'(i), 1'b1);
    check("steady_cnt", 32'(q.size()), 32'd2);
    step("steady_end", 1'b1, 32'h824, 32'h0, 1'b0);

    // Random traffic over a small address window to exercise forwarding and wrap.
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      logic        rw, ack;
      logic [31:0] a;
      rw  = ($urandom_range(0, 99) >= 55);
      ack = ($urandom_range(0, 99) < 40);
      a   = 32'h300 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      step("rand", rw, a, $urandom, ack);
    end

    // Reset mid-drain clears the request and stops forwarding at once.
    pulse_reset();
    step("pre0", 1'b0, 32'h900, 32'h9999_0000, 1'b0);
    step("pre1", 1'b0, 32'h904, 32'h9999_0004, 1'b0);
    data_rd_wr = 1'b1;
    data_addr  = 32'h900;
    mem_wr_ack = 1'b0;
    #2;
    reset = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    #1;
    check("mid_rst.req", {31'h0, mem_wr_req}, 32'h0);
    check("mid_rst.full", {31'h0, wb_full}, 32'h0);
    check("mid_rst.load", data_in, backing(32'h900));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 1'b1, 32'h904, 32'h0, 1'b1);
    step("post_rst_w", 1'b0, 32'h904, 32'h1111_2222, 1'b0);
    step("post_rst_r", 1'b1, 32'h904, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_dmem_wbuf.md
MIPS_DMEM_WBUF -- requirements
Module: mips_dmem_wbuf

Interface
REQ-001 Parameter DEPTH, default 4, number of write-buffer entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data_rd_wr  input  1  core memory-stage command: 1 = read (or idle), 0 = write.
REQ-005 data_addr  input  32  core byte address; bits [1:0] SHALL be ignored (word access only).
REQ-006 data_out  input  32  core store data.
REQ-007 data_in  output  32  load data returned to core, combinational.
REQ-008 wb_full  output  1  buffer holds DEPTH entries.
REQ-009 wb_overflow  output  1  sticky: a write arrived while full and was dropped.
REQ-010 mem_rd_addr  output  32  backing-memory read address, {data_addr[31:2],2'b00}, combinational.
REQ-011 mem_rd_data  input  32  backing-memory read data, combinational from mem_rd_addr.
REQ-012 mem_wr_req  output  1  head entry valid, write request to backing memory.
REQ-013 mem_wr_addr  output  32  head entry word address.
REQ-014 mem_wr_data  output  32  head entry data.
REQ-015 mem_wr_ack  input  1  backing memory accepts head entry this cycle.

Function
REQ-016 Block SHALL be a circular FIFO of {addr[31:2], data[31:0]} with head pointer, tail pointer and count (0..DEPTH).
REQ-017 Push: when data_rd_wr=0 and wb_full=0 at a rising edge, {data_addr[31:2], data_out} SHALL be written at tail; tail increments modulo DEPTH.
REQ-018 Push when full: when data_rd_wr=0 and wb_full=1, the write SHALL be dropped, FIFO unchanged, wb_overflow set to 1 from the next cycle until reset; an ack in the same cycle SHALL NOT make room for the write.
REQ-019 Drain: mem_wr_req SHALL equal (count != 0); mem_wr_addr/mem_wr_data SHALL show head entry and stay stable until the cycle mem_wr_req=1 and mem_wr_ack=1.
REQ-020 Pop: on a rising edge with mem_wr_req=1 and mem_wr_ack=1, head increments modulo DEPTH; mem_wr_ack with mem_wr_req=0 SHALL be ignored.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pointers both advance.
REQ-022 Push-to-request latency: a write into an empty buffer SHALL assert mem_wr_req the following cycle; no bypass to backing memory.
REQ-023 Read forwarding: data_in SHALL be the data of the newest valid entry whose addr equals data_addr[31:2]; if none match, data_in = mem_rd_data.
REQ-024 Newest SHALL be determined by age from tail, not by index; older duplicates SHALL remain in order and drain normally (no coalescing).
REQ-025 Entry popped in the current cycle SHALL still forward in that cycle; entry pushed in the current cycle SHALL forward only from the next cycle.
REQ-026 data_in SHALL be driven regardless of data_rd_wr.
REQ-027 wb_full SHALL equal (count == DEPTH), registered-state derived, no combinational path from mem_wr_ack.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0 without gaps; count SHALL never exceed DEPTH or underflow.

Reset
REQ-029 While reset=1, asynchronously: count=0, head=tail=0, wb_overflow=0, mem_wr_req=0, wb_full=0; pending write is abandoned without ack requirement.
REQ-030 Entry storage need not be cleared; no entry SHALL forward or drain after reset.
REQ-031 Writes presented while reset=1 SHALL be ignored.

Verification
REQ-032 Reset, write 0x1234_5678 to 0x100, ack held 0 -> next cycle mem_wr_req=1, mem_wr_addr=0x100, mem_wr_data=0x1234_5678; read 0x100 with mem_rd_data=0 -> data_in=0x1234_5678.
REQ-033 Writes 0xA then 0xB to 0x200, ack=0 -> read 0x203 returns 0xB; ack twice -> backing sees 0xA then 0xB in order.
REQ-034 DEPTH=4, five writes with ack=0 -> wb_full=1 after fourth, fifth dropped, wb_overflow=1 sticky; four acks drain 4 entries, wb_full=0.
REQ-035 Full buffer, write and ack same cycle -> write dropped, count=3, wb_overflow=1.
REQ-036 Count=2, push and ack same cycle for 10 cycles -> count stays 2, pointers wrap, drain order equals push order.
REQ-037 Assert reset mid-drain with mem_wr_req=1 -> mem_wr_req=0 immediately, read of previously buffered address returns mem_rd_data.
